sd_block_sequencer: RTL and testbench

//  Drives the SD SPI controller's single-block read port to stream a contiguous run of
//  NUM_BLOCKS sectors, starting at a given sector, into an on-chip image buffer (BRAM).

---
 rtl/sd_block_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_sd_block_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_sequencer.sv
// Streams NUM_BLOCKS consecutive SD sectors through the SD controller's single-block
// read port and writes every received byte, in order, into a linear image buffer.
module sd_block_sequencer #(
  parameter int unsigned NUM_BLOCKS     = 38,
  parameter int unsigned MEM_AW         = 15,
  parameter bit          BLOCK_ADDR     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       base_block,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic              sd_ready,
  output logic              sd_rd,
  output logic [31:0]       sd_address,
  input  logic              sd_byte_available,
  input  logic [7:0]        sd_dout,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [2:0]        dbg_state
);

  localparam int unsigned BLK_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [9:0]  BLK_BYTES = 10'd512;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_STREAM   = 3'd3,
    ST_NEXT     = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         base_q, base_d;
  logic [BLK_W-1:0]    block_idx_q, block_idx_d;
  logic [9:0]          byte_idx_q, byte_idx_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                avail_prev_q;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                sd_rd_q, sd_rd_d;
  logic [31:0]         sd_address_q, sd_address_d;
  logic                mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;

  logic                byte_edge;
  logic                blk_full;
  logic                last_blk;
  logic                tmo;
  logic                start_ok;
  logic [MEM_AW-1:0]   wr_addr;
  logic [31:0]         blk_ext;
  logic [31:0]         addr_off;

  // A strobe held high for several cycles must count as one byte.
  assign byte_edge = sd_byte_available & ~avail_prev_q;
  assign blk_full  = (byte_idx_q == BLK_BYTES);
  assign last_blk  = (block_idx_q == BLK_W'(NUM_BLOCKS - 1));
  assign tmo       = (timer_q == TMR_W'(TIMEOUT_CYCLES));
  assign start_ok  = start & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR));
  assign wr_addr   = MEM_AW'({block_idx_q, byte_idx_q[8:0]});
  assign blk_ext   = 32'(block_idx_q);
  assign addr_off  = BLOCK_ADDR ? blk_ext : {blk_ext[22:0], 9'd0};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      block_idx_q  <= '0;
      byte_idx_q   <= '0;
      timer_q      <= '0;
      avail_prev_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      sd_rd_q      <= 1'b0;
      sd_address_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      block_idx_q  <= block_idx_d;
      byte_idx_q   <= byte_idx_d;
      timer_q      <= timer_d;
      avail_prev_q <= sd_byte_available;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      sd_rd_q      <= sd_rd_d;
      sd_address_q <= sd_address_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start_ok) state_d = ST_WAIT_RDY;
      ST_WAIT_RDY: if (sd_ready) state_d = ST_ISSUE;
      ST_ISSUE:    if (!sd_ready) state_d = ST_STREAM;
      ST_STREAM: begin
        if (tmo) begin
          state_d = ST_ERR;
        end else if (byte_edge) begin
          if (blk_full) state_d = ST_ERR;
        end else if (sd_ready) begin
          state_d = blk_full ? ST_NEXT : ST_ERR;
        end
      end
      ST_NEXT:  state_d = last_blk ? ST_DONE : ST_WAIT_RDY;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    base_d       = base_q;
    block_idx_d  = block_idx_q;
    byte_idx_d   = byte_idx_q;
    timer_d      = timer_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    sd_rd_d      = sd_rd_q;
    sd_address_d = sd_address_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok) begin
          base_d      = base_block;
          block_idx_d = '0;
          byte_idx_d  = '0;
          timer_d     = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
        end
      end
      ST_WAIT_RDY: begin
        timer_d = '0;
        if (sd_ready) begin
          sd_rd_d      = 1'b1;
          sd_address_d = base_q + addr_off;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        if (!sd_ready) sd_rd_d = 1'b0;
      end
      ST_STREAM: begin
        if (!tmo) begin
          if (byte_edge) begin
            timer_d = '0;
            if (!blk_full) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = wr_addr;
              mem_wdata_d = sd_dout;
              byte_idx_d  = byte_idx_q + 10'd1;
            end
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      ST_NEXT: begin
        byte_idx_d = '0;
        if (!last_blk) block_idx_d = block_idx_q + BLK_W'(1);
      end
      default: ;
    endcase
    // Status levels change together with the state that owns them.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    if (state_d == ST_ERR && state_q != ST_ERR) begin
      busy_d  = 1'b0;
      error_d = 1'b1;
      sd_rd_d = 1'b0;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign sd_rd      = sd_rd_q;
  assign sd_address = sd_address_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sd_block_sequencer.sv
// Directed bench for sd_block_sequencer: a behavioural SD read model feeds two instances
// (block and byte addressing) sharing all inputs; writes and requests go to a scoreboard.
`timescale 1ns/1ps
module tb_sd_block_sequencer;

  localparam int NB  = 2;
  localparam int AW  = 15;
  localparam int TMO = 200;
  localparam int W   = AW + 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [31:0]   base_block = 32'h0;
  logic          sd_ready;
  logic          sd_byte_available;
  logic [7:0]    sd_dout;

  logic          busy_a, done_a, error_a, sd_rd_a, mem_we_a;
  logic [31:0]   sd_address_a;
  logic [AW-1:0] mem_addr_a;
  logic [7:0]    mem_wdata_a;
  logic [2:0]    dbg_state_a;
  logic          busy_b, done_b, error_b, sd_rd_b, mem_we_b;
  logic [31:0]   sd_address_b;
  logic [AW-1:0] mem_addr_b;
  logic [7:0]    mem_wdata_b;
  logic [2:0]    dbg_state_b;

  sd_block_sequencer #(.NUM_BLOCKS(NB), .MEM_AW(AW), .BLOCK_ADDR(1'b1), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .base_block(base_block),
    .busy(busy_a), .done(done_a), .error(error_a),
    .sd_ready(sd_ready), .sd_rd(sd_rd_a), .sd_address(sd_address_a),
    .sd_byte_available(sd_byte_available), .sd_dout(sd_dout),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .dbg_state(dbg_state_a)
  );

  sd_block_sequencer #(.NUM_BLOCKS(NB), .MEM_AW(AW), .BLOCK_ADDR(1'b0), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .base_block(base_block),
    .busy(busy_b), .done(done_b), .error(error_b),
    .sd_ready(sd_ready), .sd_rd(sd_rd_b), .sd_address(sd_address_b),
    .sd_byte_available(sd_byte_available), .sd_dout(sd_dout),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .dbg_state(dbg_state_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // SD model controls
  int hold_base = 1;
  bit hold_alt = 1'b0;
  int gap = 1;
  int nbytes = 512;
  int stall_at = -1;
  bit model_abort = 1'b0;
  bit not_ready = 1'b0;
  bit model_busy = 1'b0;

  function automatic logic [7:0] model_data(input logic [31:0] a, input int i);
    logic [31:0] t;
    t = a * 32'd13 + 32'(i);
    return t[7:0];
  endfunction

  initial begin
    logic [31:0] req;
    sd_ready = 1'b1;
    sd_byte_available = 1'b0;
    sd_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_n && sd_rd_a && !model_abort) begin
        model_busy = 1'b1;
        req = sd_address_a;
        @(negedge clk);
        sd_ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < nbytes && !model_abort; i++) begin
          if (i == stall_at) begin
            while (!model_abort) @(negedge clk);
          end else begin
            sd_dout = model_data(req, i);
            sd_byte_available = 1'b1;
            repeat (hold_base + (hold_alt ? (i % 2) : 0)) @(negedge clk);
            sd_byte_available = 1'b0;
            repeat (gap) @(negedge clk);
          end
        end
        sd_byte_available = 1'b0;
        sd_ready = 1'b1;
        model_busy = 1'b0;
      end else begin
        sd_ready = !not_ready;
      end
    end
  end

  // monitor / scoreboard capture
  logic [W-1:0]  obs_q[$];
  logic [W-1:0]  exp_q[$];
  logic [31:0]   req_a_q[$];
  logic [31:0]   req_b_q[$];
  int            wr_b_cnt = 0;
  int            cyc = 0;
  int            last_wr_cyc = 0;
  int            err_cyc = 0;
  logic          rd_prev_a = 1'b0, rd_prev_b = 1'b0, err_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we_a) begin
      obs_q.push_back({mem_addr_a, mem_wdata_a});
      last_wr_cyc <= cyc;
    end
    if (mem_we_b) wr_b_cnt <= wr_b_cnt + 1;
    if (sd_rd_a && !rd_prev_a) req_a_q.push_back(sd_address_a);
    if (sd_rd_b && !rd_prev_b) req_b_q.push_back(sd_address_b);
    if (error_a && !err_prev) err_cyc <= cyc;
    rd_prev_a <= sd_rd_a;
    rd_prev_b <= sd_rd_b;
    err_prev  <= error_a;
  end

  int obs_base = 0, ra_base = 0, rb_base = 0, wb_base = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [31:0] base, input int nblk, input int extra);
    int nb;
    exp_q.delete();
    for (int k = 0; k <= nblk; k++) begin
      nb = (k < nblk) ? 512 : extra;
      for (int i = 0; i < nb; i++)
        exp_q.push_back({AW'(k * 512 + i), model_data(base + 32'(k), i)});
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    int bad;
    n = obs_q.size() - obs_base;
    bad = 0;
    check({tag, "_wr_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      if (obs_q[obs_base + i] !== exp_q[i]) bad++;
    check({tag, "_wr_seq_bad"}, 64'(bad), 64'd0);
  endtask

  task automatic check_reqs(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] b0, input logic [31:0] b1);
    check({tag, "_req_cnt"}, 64'(req_a_q.size() - ra_base), 64'd2);
    check({tag, "_req_a0"}, req_a_q[ra_base], a0);
    check({tag, "_req_a1"}, req_a_q[ra_base + 1], a1);
    check({tag, "_req_b0"}, req_b_q[rb_base], b0);
    check({tag, "_req_b1"}, req_b_q[rb_base + 1], b1);
  endtask

  // driver tasks
  task automatic do_start(input logic [31:0] base);
    obs_base = obs_q.size();
    ra_base  = req_a_q.size();
    rb_base  = req_b_q.size();
    wb_base  = wr_b_cnt;
    @(negedge clk);
    start = 1'b1;
    base_block = base;
    @(negedge clk);
    start = 1'b0;
    base_block = 32'h0;
    check("start_busy", busy_a, 1);
    check("start_done_clr", done_a, 0);
    check("start_err_clr", error_a, 0);
  endtask

  task automatic wait_end(input int limit);
    int waited;
    waited = 0;
    while (!(done_a || error_a) && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    check("end_within_bound", 64'(waited < limit), 64'd1);
    @(negedge clk);
  endtask

  task automatic release_model();
    int n;
    n = 0;
    model_abort = 1'b1;
    while (model_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("model_release", model_busy, 0);
    model_abort = 1'b0;
    stall_at = -1;
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, done_a, 1);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_error"}, error_a, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_flags", {busy_a, done_a, error_a, sd_rd_a, mem_we_a}, 5'b0);
    check("rst_sd_address", sd_address_a, 32'h0);
    check("rst_mem", {mem_addr_a, mem_wdata_a}, '0);
    check("rst_state", dbg_state_a, 3'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic two-block transfer
    do_start(32'h100);
    wait_end(8000);
    check_done("t1");
    check_reqs("t1", 32'h100, 32'h101, 32'h100, 32'h300);
    build_exp(32'h100, 2, 0);
    compare_writes("t1");

    // 2: byte addressing steps by 512
    gap = 2;
    do_start(32'h200);
    wait_end(8000);
    check_done("t2");
    check_reqs("t2", 32'h200, 32'h201, 32'h200, 32'h400);
    check("t2_wr_b_count", 64'(wr_b_cnt - wb_base), 64'd1024);
    build_exp(32'h200, 2, 0);
    compare_writes("t2");

    // 3: strobes held 2-3 cycles
    gap = 1; hold_base = 2; hold_alt = 1'b1;
    do_start(32'h100);
    wait_end(8000);
    check_done("t3");
    build_exp(32'h100, 2, 0);
    compare_writes("t3");

    // 4: card stalls after 100 bytes -> timeout, then recovery
    hold_base = 1; hold_alt = 1'b0; stall_at = 100;
    do_start(32'h100);
    wait_end(3000);
    check("t4_error", error_a, 1);
    check("t4_busy", busy_a, 0);
    check("t4_sd_rd", sd_rd_a, 0);
    check("t4_done", done_a, 0);
    check("t4_timeout_cycles", 64'(err_cyc - last_wr_cyc), 64'(TMO + 1));
    build_exp(32'h100, 0, 100);
    compare_writes("t4");
    release_model();
    do_start(32'h100);
    wait_end(8000);
    check_done("t4r");
    build_exp(32'h100, 2, 0);
    compare_writes("t4r");

    // 5: card not ready for a long time; start while busy is ignored
    not_ready = 1'b1;
    repeat (2) @(negedge clk);
    do_start(32'h100);
    repeat (1000) @(negedge clk);
    start = 1'b1; base_block = 32'h999;
    @(negedge clk);
    start = 1'b0; base_block = 32'h0;
    repeat (2000) @(negedge clk);
    check("t5_state", dbg_state_a, 3'd1);
    check("t5_sd_rd", sd_rd_a, 0);
    check("t5_error", error_a, 0);
    check("t5_busy", busy_a, 1);
    check("t5_no_writes", 64'(obs_q.size() - obs_base), 64'd0);
    not_ready = 1'b0;
    wait_end(8000);
    check_done("t5");
    check_reqs("t5", 32'h100, 32'h101, 32'h100, 32'h300);
    build_exp(32'h100, 2, 0);
    compare_writes("t5");

    // 6: asynchronous reset in the middle of block 1
    do_start(32'h100);
    n = 0;
    while ((obs_q.size() - obs_base) < 562 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_block1", 64'(n < 5000), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_flags", {busy_a, done_a, error_a, sd_rd_a, mem_we_a}, 5'b0);
    check("t6_rst_sd_address", sd_address_a, 32'h0);
    check("t6_rst_mem", {mem_addr_a, mem_wdata_a}, '0);
    check("t6_rst_state", dbg_state_a, 3'd0);
    release_model();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    do_start(32'h100);
    wait_end(8000);
    check_done("t6");
    check_reqs("t6", 32'h100, 32'h101, 32'h100, 32'h300);
    build_exp(32'h100, 2, 0);
    compare_writes("t6");

    // 7: card reports ready after only 10 bytes
    nbytes = 10;
    do_start(32'h100);
    wait_end(3000);
    check("t7_error", error_a, 1);
    check("t7_done", done_a, 0);
    build_exp(32'h100, 0, 10);
    compare_writes("t7");

    // 8: 513th byte in one block
    nbytes = 513;
    do_start(32'h100);
    wait_end(3000);
    check("t8_error", error_a, 1);
    check("t8_state", dbg_state_a, 3'd6);
    build_exp(32'h100, 1, 0);
    compare_writes("t8");
    nbytes = 512;
    repeat (5) @(negedge clk);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
